// File: rtl/card_dealer_arbiter.sv
// Shared card source for the blackjack game: free-running LFSR, dealt-card bitmap,
// and round-robin arbitration between player and dealer draw requests.
//
// state  | meaning
// IDLE   | waiting for a request; watches for an exhausted deck
// SEARCH | stepping the LFSR until it lands on an undealt card
// GRANT  | one-cycle grant pulse to the latched winner
// EMPTY  | no cards left; only a shuffle leaves this state
module card_dealer_arbiter #(
  parameter logic [5:0] SEED = 6'b011110
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_player,
  input  logic       req_dealer,
  input  logic       shuffle,
  output logic       grant_player,
  output logic       grant_dealer,
  output logic [3:0] card_rank,
  output logic [1:0] card_suit,
  output logic [5:0] cards_left,
  output logic       deck_empty,
  output logic       busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEARCH = 2'd1;
  localparam logic [1:0] ST_GRANT  = 2'd2;
  localparam logic [1:0] ST_EMPTY  = 2'd3;

  localparam logic SIDE_PLAYER = 1'b0;
  localparam logic SIDE_DEALER = 1'b1;

  localparam logic [5:0] DECK_SIZE = 6'd52;

  logic [1:0]  state;
  logic [5:0]  lfsr;
  logic [51:0] used;
  logic        winner;
  logic        last_served;

  logic [5:0]  idx;
  logic        idx_valid;
  logic        idx_taken;
  logic        idx_free;
  logic [5:0]  suit_base;
  logic [1:0]  cand_suit;
  logic [3:0]  cand_rank;
  logic        pick;

  // LFSR never reaches zero, so idx spans 0..62; 52..62 are not cards.
  assign idx       = lfsr - 6'd1;
  assign idx_valid = (idx < DECK_SIZE);
  assign idx_taken = idx_valid ? used[idx] : 1'b1;
  assign idx_free  = idx_valid && !idx_taken;

  always_comb begin
    cand_suit = 2'd0;
    suit_base = 6'd0;
    if (idx >= 6'd39) begin
      cand_suit = 2'd3;
      suit_base = 6'd39;
    end else if (idx >= 6'd26) begin
      cand_suit = 2'd2;
      suit_base = 6'd26;
    end else if (idx >= 6'd13) begin
      cand_suit = 2'd1;
      suit_base = 6'd13;
    end
    cand_rank = 4'(idx - suit_base + 6'd1);
  end

  // On a tie the side not served last wins; a lone requester always wins.
  always_comb begin
    if (req_player && req_dealer) pick = ~last_served;
    else                          pick = req_dealer ? SIDE_DEALER : SIDE_PLAYER;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      lfsr        <= SEED;
      used        <= '0;
      cards_left  <= DECK_SIZE;
      card_rank   <= 4'd0;
      card_suit   <= 2'd0;
      winner      <= SIDE_PLAYER;
      last_served <= SIDE_DEALER;
    end else begin
      lfsr <= {lfsr[4:0], lfsr[5] ^ lfsr[4]};
      case (state)
        ST_IDLE: begin
          if (shuffle) begin
            state <= ST_IDLE;
          end else if (cards_left == 6'd0) begin
            state <= ST_EMPTY;
          end else if (req_player || req_dealer) begin
            winner <= pick;
            state  <= ST_SEARCH;
          end
        end
        ST_SEARCH: begin
          if (!shuffle && idx_free) begin
            card_rank  <= cand_rank;
            card_suit  <= cand_suit;
            used[idx]  <= 1'b1;
            cards_left <= cards_left - 6'd1;
            state      <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          last_served <= winner;
          state       <= ST_IDLE;
        end
        ST_EMPTY: begin
          state <= ST_EMPTY;
        end
      endcase
      // A shuffle overrides the deck and state from any state; an in-flight
      // grant pulse still completes because it is decoded from the current state.
      if (shuffle) begin
        used       <= '0;
        cards_left <= DECK_SIZE;
        state      <= ST_IDLE;
      end
    end
  end

  assign grant_player = (state == ST_GRANT) && (winner == SIDE_PLAYER);
  assign grant_dealer = (state == ST_GRANT) && (winner == SIDE_DEALER);
  assign busy         = (state == ST_SEARCH) || (state == ST_GRANT);
  assign deck_empty   = (cards_left == 6'd0);

endmodule
